pix_frame_writer: RTL
=====================

PIX_FRAME_WRITER -- requirements
Module: pix_frame_writer

Interface
REQ-001 The block SHALL have parameter BASE0, default 32'h0000_0000, byte base address of frame buffer 0.
REQ-002 The block SHALL have parameter BASE1, default 32'h0017_7000, byte base address of frame buffer 1.
REQ-003 The block SHALL have parameter FRAME_PIXELS, default 384000, pixels per frame (800x480).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two).
REQ-005 The block SHALL have port iCLK input 1: clock.
REQ-006 The block SHALL have port iRST input 1: reset, synchronous, active-high.
REQ-007 The block SHALL have port iPix_Data input 24: RGB pixel from the SPI slave.
REQ-008 The block SHALL have port iTrigger input 1: one-cycle pulse, iPix_Data valid.
REQ-009 The block SHALL have port iImg_Tot input 8: image counter from the SPI slave.
REQ-010 The block SHALL have port oAvm_Address output 32: Avalon-MM master byte address.
REQ-011 The block SHALL have port oAvm_Write output 1: Avalon-MM write request.
REQ-012 The block SHALL have port oAvm_WriteData output 32: {8'h00, pixel}.
REQ-013 The block SHALL have port iAvm_WaitRequest input 1: slave stall.
REQ-014 The block SHALL have port oFrame_Sel output 1: buffer index the display reads.
REQ-015 The block SHALL have port oFrame_Done output 1: one-cycle pulse per completed frame.
REQ-016 The block SHALL have port oOverflow output 1: sticky flag, pixel dropped.

Function
REQ-017 On iTrigger=1 with the FIFO not full, the block SHALL push iPix_Data in that cycle.
REQ-018 On iTrigger=1 with the FIFO full, the pixel SHALL be dropped and oOverflow set, even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-020 The FSM SHALL have states IDLE and WRITE.
REQ-021 IDLE -> WRITE when the FIFO is non-empty: pop the head into the output registers and assert oAvm_Write in the next cycle.
REQ-022 Latency from iTrigger at cycle N into an empty idle block to oAvm_Write=1 SHALL be 2 cycles (cycle N+2).
REQ-023 In WRITE, oAvm_Address and oAvm_WriteData SHALL remain stable while iAvm_WaitRequest=1.
REQ-024 A transfer completes in a WRITE cycle with iAvm_WaitRequest=0.
REQ-025 On completion with the FIFO non-empty, the block SHALL pop the next pixel and stay in WRITE (back-to-back, no idle cycle).
REQ-026 On completion with the FIFO empty, the block SHALL deassert oAvm_Write and go to IDLE.
REQ-027 oAvm_Address SHALL equal (wbuf ? BASE1 : BASE0) + 4*pix_cnt, where pix_cnt is the 19-bit pixel index and wbuf is the write-buffer bit.
REQ-028 On completion, pix_cnt SHALL increment.
REQ-029 On completion with pix_cnt == FRAME_PIXELS-1, the block SHALL: wrap pix_cnt to 0, set oFrame_Sel to the old wbuf, toggle wbuf, and pulse oFrame_Done for one cycle.
REQ-030 A change of iImg_Tot versus its registered copy SHALL set a resync flag.
REQ-031 The resync flag SHALL be applied at the next pop, or immediately if in IDLE: pix_cnt=0, no buffer swap, no oFrame_Done.
REQ-032 When a resync and a frame wrap coincide, the wrap actions SHALL take precedence and the flag SHALL clear.
REQ-033 oOverflow SHALL clear only on iRST.

Reset
REQ-034 While iRST=1: oAvm_Write=0, oAvm_Address=BASE0, oAvm_WriteData=0, oFrame_Done=0, oOverflow=0, oFrame_Sel=1, wbuf=0, pix_cnt=0, FIFO empty, resync flag clear, FSM in IDLE.
REQ-035 Reset mid-transfer SHALL drop oAvm_Write in the next cycle and discard all buffered pixels.
REQ-036 iImg_Tot SHALL be captured into its registered copy during reset, so that no spurious resync occurs afterwards.

Structure
REQ-037 Package pix_pkg SHALL hold the FSM state typedef and the constants MTL_WIDTH=800, MTL_HEIGHT=480, PIX_W=24.
REQ-038 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, registered read data, full/empty outputs).

Verification
REQ-039 Scenario: single trigger with 24'hA1B2C3, WaitRequest=0 -> one write at BASE0, data 32'h00A1B2C3, at cycle N+2.
REQ-040 Scenario: 5 triggers while WaitRequest=1 for 20 cycles, then 0 -> 5 consecutive writes at BASE0+0..16, address/data stable during the stall, oOverflow=0.
REQ-041 Scenario: 17 triggers with WaitRequest held 1 -> oOverflow=1, exactly 16 writes after release, 17th pixel absent.
REQ-042 Scenario: FRAME_PIXELS=4, 9 pixels -> addresses BASE0+0..12, BASE1+0..12, BASE0+0; oFrame_Done pulses after writes 4 and 8; oFrame_Sel goes 0 then 1.
REQ-043 Scenario: iImg_Tot 3->4 after 2 pixels -> next pixel written at base+0 of the same buffer, no oFrame_Done.
REQ-044 Scenario: iRST asserted during a stalled write -> oAvm_Write=0 next cycle, FIFO empty, all outputs at their reset values.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared types and constants for the pixel frame writer.
package pix_pkg;

    localparam int unsigned MTL_WIDTH  = 800;
    localparam int unsigned MTL_HEIGHT = 480;
    localparam int unsigned PIX_W      = 24;
    localparam int unsigned AVM_W      = 32;
    localparam int unsigned CNT_W      = 19;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

    // Byte address of a 32-bit pixel word inside a frame buffer
    function automatic logic [AVM_W-1:0] pix_addr(input logic [AVM_W-1:0] base,
                                                  input logic [CNT_W-1:0] cnt);
        return base + AVM_W'({cnt, 2'b00});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty/count.
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_ok_c;
    logic             rd_ok_c;

    always_comb begin
        wr_ok_c   = wr_en & ~full_q;
        rd_ok_c   = rd_en & ~empty_q;
        wr_ptr_d  = wr_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_ok_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
        full_d    = (count_d == CW'(DEPTH));
        empty_d   = (count_d == '0);
        rd_data_d = rd_ok_c ? mem_q[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage array carries no reset; only pointers define validity
    always_ff @(posedge iCLK) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/pix_frame_writer.sv
// Buffers SPI pixels and writes them as 32-bit words into a double-buffered
// frame store over Avalon-MM, swapping buffers at each completed frame.
module pix_frame_writer
    import pix_pkg::*;
#(
    parameter logic [31:0] BASE0        = 32'h0000_0000,
    parameter logic [31:0] BASE1        = 32'h0017_7000,
    parameter int unsigned FRAME_PIXELS = 384000,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [PIX_W-1:0]  iPix_Data,
    input  logic              iTrigger,
    input  logic [7:0]        iImg_Tot,
    output logic [AVM_W-1:0]  oAvm_Address,
    output logic              oAvm_Write,
    output logic [AVM_W-1:0]  oAvm_WriteData,
    input  logic              iAvm_WaitRequest,
    output logic              oFrame_Sel,
    output logic              oFrame_Done,
    output logic              oOverflow
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH+1);
    localparam int unsigned OCW = FCW + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

    wr_state_e        state_q, state_d;
    logic             write_q, write_d;
    logic [AVM_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wbuf_q, wbuf_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             resync_q, resync_d;
    logic [7:0]       img_tot_q, img_tot_d;

    logic             resync_pend_c;
    logic             push_c;
    logic             pop_c;
    logic             pix_full_c;
    logic [OCW-1:0]   occupancy_c;

    logic [PIX_W-1:0] fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    function automatic logic [AVM_W-1:0] base_of(input logic buf_sel);
        return buf_sel ? BASE1 : BASE0;
    endfunction

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .wr_en   (push_c),
        .wr_data (iPix_Data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The pixel held in the output stage counts toward capacity
    always_comb begin
        occupancy_c = OCW'(fifo_count) + OCW'(write_q);
        pix_full_c  = fifo_full | (occupancy_c >= OCW'(FIFO_DEPTH));
        push_c      = iTrigger & ~pix_full_c;
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        wbuf_d        = wbuf_q;
        sel_d         = sel_q;
        done_d        = 1'b0;
        resync_pend_c = resync_q;
        pop_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (resync_pend_c) begin
                    cnt_d         = '0;
                    resync_pend_c = 1'b0;
                end
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    write_d = 1'b1;
                    state_d = WRITE;
                    addr_d  = pix_addr(base_of(wbuf_d), cnt_d);
                end
            end
            WRITE: begin
                if (!iAvm_WaitRequest) begin
                    // Frame wrap wins over a pending resync and consumes it
                    if (cnt_q == LAST_PIX) begin
                        cnt_d         = '0;
                        sel_d         = wbuf_q;
                        wbuf_d        = ~wbuf_q;
                        done_d        = 1'b1;
                        resync_pend_c = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!fifo_empty) begin
                        pop_c = 1'b1;
                        if (resync_pend_c) begin
                            cnt_d         = '0;
                            resync_pend_c = 1'b0;
                        end
                        addr_d = pix_addr(base_of(wbuf_d), cnt_d);
                    end else begin
                        write_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        resync_d   = resync_pend_c | (iImg_Tot != img_tot_q);
        overflow_d = overflow_q | (iTrigger & pix_full_c);
        img_tot_d  = iImg_Tot;
    end

    // Image counter is tracked through reset so release never looks like a change
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= BASE0;
            cnt_q      <= '0;
            wbuf_q     <= 1'b0;
            sel_q      <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
            img_tot_q  <= iImg_Tot;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wbuf_q     <= wbuf_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
            img_tot_q  <= img_tot_d;
        end
    end

    assign oAvm_Write     = write_q;
    assign oAvm_Address   = addr_q;
    assign oAvm_WriteData = {(AVM_W-PIX_W)'(0), fifo_rd_data};
    assign oFrame_Sel     = sel_q;
    assign oFrame_Done    = done_q;
    assign oOverflow      = overflow_q;

endmodule
